mem_bus: RTL and testbench
==========================

# mem_bus

Bus responder on the far end of the CPU memory port. It services the CPU's single-cycle read and write requests against an on-chip word RAM. It also decodes a small I/O window that holds a buffered UART transmitter. It sits between the `cpu` instance and the FPGA pins, and is the only target on the bus.

## Interface
- `DEPTH`, 4096: RAM size in 32-bit words; power of two, at most 8192.
- `INIT_FILE`, "": hex image loaded into RAM at elaboration; empty string means no load.
- `CLK_DIV`, 104: clock cycles per UART bit; minimum 2.
- `clk` in 1: system clock; the only clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `ren` in 1: read request, sampled on the rising edge.
- `addr` in 16: byte address. Bit 15 selects I/O (1) or RAM (0). Bits 1:0 are ignored for word indexing.
- `rdata` out 32: read data, registered.
- `rd_valid` out 1: one-cycle pulse, aligned with fresh `rdata`.
- `wen` in 1: write request, sampled on the rising edge.
- `wdata` out-of-CPU / in 32: write data, already lane-shifted by the CPU.
- `wmask` in 4: byte enables. `wmask[3]` controls `wdata[7:0]`, `[2]` controls `[15:8]`, `[1]` controls `[23:16]`, `[0]` controls `[31:24]`.
- `uart_tx` out 1: serial output, idles high.

## Operation
- RAM read: on edge k with `ren`=1, `rdata` takes `ram[addr[14:2] mod DEPTH]` and `rd_valid`=1 after k. `rd_valid` drops after k+1 unless `ren` is still high.
- `rdata` holds its last value while `ren`=0.
- RAM write: on an edge with `wen`=1, each enabled byte lane updates. Disabled lanes keep their old value.
- `ren` and `wen` both high: the write executes; the read is ignored and `rd_valid`=0.
- Read-after-write: a read of the same word one cycle after a write returns the new data.
- I/O map (`addr[15]`=1, decoded on `addr[3:2]`):
  - 0x8000 TXDATA. A write with `wmask[3]`=1 pushes `wdata[7:0]` into the TX FIFO. A read returns 0.
  - 0x8004 STATUS, read-only:
    - bit0 busy: FIFO not empty, or shifter active.
    - bit1 FIFO full.
    - bit2 overflow, sticky.
    - other bits read 0.
  - Other I/O addresses read 0; writes to them are ignored.
- TX FIFO: 4 entries.
  - A push when full is dropped and sets overflow.
  - A STATUS read returns the current overflow value and clears it on the same edge.
  - A push on the same edge as a clear leaves overflow=1.
- Shifter states: IDLE → START → DATA(8 bits, LSB first) → STOP → IDLE.
  - Each state lasts `CLK_DIV` cycles.
  - Pops happen only in IDLE with the FIFO non-empty.
  - From STOP with the FIFO non-empty, the shifter goes directly to START with no extra idle bit.
  - A push and a pop on the same edge are both honoured; occupancy is unchanged.
- Reset values:
  - `rdata`=0, `rd_valid`=0, `uart_tx`=1.
  - FIFO empty, overflow=0, shifter IDLE, baud counter 0.
  - RAM contents are not reset.
- Reset mid-frame: `uart_tx` goes high asynchronously, and the frame and all queued bytes are lost.

## Timing
- Read latency is fixed at 1 cycle, with no wait states. The CPU samples `rdata` in the state after asserting `ren`, so this latency is mandatory.
- Write latency is 0 to the array. The written data is visible to the next edge's read.
- First TX bit: `uart_tx` falls one cycle after the TXDATA write edge when the shifter is idle.
- One frame is 10×`CLK_DIV` cycles. Busy falls on the edge that ends STOP when the FIFO is empty.
- The baud counter is 16 bits; it reloads at `CLK_DIV`-1 and counts down to 0.

## Configuration
- `MEM_BUS_UART_EN` defined:
  - The I/O window and the UART are built as described.
- `MEM_BUS_UART_EN` undefined:
  - No FIFO and no shifter are built.
  - `uart_tx` is tied to 1.
  - I/O reads return 0 with a normal `rd_valid` pulse.
  - I/O writes are ignored; RAM behaviour is unchanged.

## Structure
- `common.v` holds the following constants:
  - I/O base 0x8000.
  - Register offsets `IO_TXDATA`=0x0 and `IO_STATUS`=0x4.
  - STATUS bit indices.
  - UART shifter state encodings.
- The reset and stack vectors in `common.v` must fall inside RAM, i.e. below `DEPTH`×4.
- One sub-module, `uart_tx`: FIFO, baud counter and shifter. Its ports are `clk`, `rst_n`, push, data[7:0], busy, full, overflow-clear, overflow and `tx`.
- `mem_bus` keeps the RAM array, address decode, byte-lane merge and read mux.

## Test plan
- Write word 0x11223344 to 0x0100 with `wmask`=1111, then read 0x0100 → `rdata`=0x11223344 with `rd_valid` high for exactly one cycle, one cycle after `ren`.
- Byte lanes: preload 0xAABBCCDD, write `wdata`=0x00000055 with `wmask`=1000 → reads 0xAABBCC55. Then write 0x66000000 with `wmask`=0001 → reads 0x66BBCC55.
- Collision: assert `ren` and `wen` together at 0x0200 → write lands and `rd_valid` stays 0. A next-cycle read returns the new data.
- UART with `CLK_DIV`=4, write 0x8000=0xA5 → `uart_tx` carries 0,1,0,1,0,0,1,0,1,1, each bit 4 cycles. STATUS reads 0x1 during the frame and 0x0 after it.
- Push 6 bytes back-to-back with the shifter idle → the first byte pops and 4 more fill the FIFO, so the 6th is dropped. STATUS=0x7, then a second STATUS read returns bit2=0, and exactly 5 frames go out.
- Assert `rst_n` low mid-DATA → `uart_tx`=1 and `rd_valid`=0 immediately. After release STATUS=0, and RAM contents written earlier are intact.

Source files
------------

// File: rtl/mem_bus_pkg.sv
// Shared constants for the mem_bus responder: I/O map, STATUS bits, vectors, UART states.
// Also holds the byte-lane merge used on RAM writes.
package mem_bus_pkg;

  localparam logic [15:0] IO_BASE   = 16'h8000;
  localparam logic [3:0]  IO_TXDATA = 4'h0;
  localparam logic [3:0]  IO_STATUS = 4'h4;

  localparam int ST_BUSY = 0;
  localparam int ST_FULL = 1;
  localparam int ST_OVF  = 2;

  // Both vectors must stay below DEPTH*4 for the smallest RAM that gets built.
  localparam logic [15:0] RESET_VEC = 16'h0000;
  localparam logic [15:0] STACK_VEC = 16'h0FFC;

  localparam logic [2:0] TX_FIFO_DEPTH = 3'd4;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_DATA  = 2'd2,
    TX_STOP  = 2'd3
  } tx_state_e;

  // wmask is big-endian against the word: wmask[3] enables wdata[7:0].
  function automatic logic [31:0] lane_merge(input logic [31:0] old_w,
                                             input logic [31:0] new_w,
                                             input logic [3:0]  mask);
    logic [31:0] res;
    res = old_w;
    for (int i = 0; i < 4; i++) begin
      if (mask[3-i]) res[8*i +: 8] = new_w[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/mem_bus_uart_tx.sv
// Buffered 8N1 transmitter: 4-entry FIFO, 16-bit baud counter, IDLE/START/DATA/STOP shifter.
// tx falls one cycle after a push into an idle unit; pushes into a full FIFO are dropped and flag overflow.
module mem_bus_uart_tx
  import mem_bus_pkg::*;
#(
  parameter int CLK_DIV = 104
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push,
  input  logic [7:0] data,
  output logic       busy,
  output logic       full,
  input  logic       ovf_clr,
  output logic       ovf,
  output logic       tx
);

  localparam logic [15:0] RELOAD = 16'(CLK_DIV - 1);

  logic [7:0]  fifo_q [4];
  logic [7:0]  fifo_d [4];
  logic [1:0]  rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        ovf_q, ovf_d;
  tx_state_e   state_q, state_d;
  logic [15:0] baud_q, baud_d;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  sh_q, sh_d;
  logic        tx_q, tx_d;
  logic        baud_done, do_pop, do_push;

  always_comb begin
    fifo_d   = fifo_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    ovf_d    = ovf_q;
    state_d  = state_q;
    baud_d   = baud_q;
    bit_d    = bit_q;
    sh_d     = sh_q;
    tx_d     = tx_q;

    baud_done = (baud_q == 16'd0);
    // A frame ending with data queued rolls straight into the next start bit.
    do_pop  = (cnt_q != 3'd0) && ((state_q == TX_IDLE) || (state_q == TX_STOP && baud_done));
    do_push = push && (cnt_q != TX_FIFO_DEPTH);

    if (ovf_clr)         ovf_d = 1'b0;
    if (push && !do_push) ovf_d = 1'b1;

    if (do_push) begin
      fifo_d[wr_ptr_q] = data;
      wr_ptr_d         = wr_ptr_q + 2'd1;
    end
    if (do_pop) rd_ptr_d = rd_ptr_q + 2'd1;
    cnt_d = cnt_q + {2'b0, do_push} - {2'b0, do_pop};

    if (do_pop) begin
      state_d = TX_START;
      baud_d  = RELOAD;
      sh_d    = fifo_q[rd_ptr_q];
      tx_d    = 1'b0;
    end else if (state_q != TX_IDLE) begin
      if (!baud_done) begin
        baud_d = baud_q - 16'd1;
      end else begin
        baud_d = RELOAD;
        case (state_q)
          TX_START: begin
            state_d = TX_DATA;
            bit_d   = 3'd0;
            tx_d    = sh_q[0];
          end
          TX_DATA: begin
            if (bit_q == 3'd7) begin
              state_d = TX_STOP;
              tx_d    = 1'b1;
            end else begin
              bit_d = bit_q + 3'd1;
              sh_d  = sh_q >> 1;
              tx_d  = sh_q[1];
            end
          end
          default: begin
            state_d = TX_IDLE;
            baud_d  = 16'd0;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fifo_q   <= '{default: '0};
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
      ovf_q    <= 1'b0;
      state_q  <= TX_IDLE;
      baud_q   <= '0;
      bit_q    <= '0;
      sh_q     <= '0;
      tx_q     <= 1'b1;
    end else begin
      fifo_q   <= fifo_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      cnt_q    <= cnt_d;
      ovf_q    <= ovf_d;
      state_q  <= state_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      sh_q     <= sh_d;
      tx_q     <= tx_d;
    end
  end

  assign busy = (cnt_q != 3'd0) || (state_q != TX_IDLE);
  assign full = (cnt_q == TX_FIFO_DEPTH);
  assign ovf  = ovf_q;
  assign tx   = tx_q;

endmodule

// File: rtl/mem_bus.sv
// mem_bus: word RAM + I/O responder; reads return 1 cycle after ren, writes land on the same edge, never stalls.
// The UART I/O window exists only with MEM_BUS_UART_EN; otherwise I/O reads 0 and uart_tx idles high.
module mem_bus
  import mem_bus_pkg::*;
#(
  parameter int    DEPTH     = 4096,
  parameter string INIT_FILE = "",
  parameter int    CLK_DIV   = 104
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ren,
  input  logic [15:0] addr,
  output logic [31:0] rdata,
  output logic        rd_valid,
  input  logic        wen,
  input  logic [31:0] wdata,
  input  logic [3:0]  wmask,
  output logic        uart_tx
);

  localparam int AW = $clog2(DEPTH);
  localparam bit HAS_INIT = (INIT_FILE != "");

  logic [31:0]   ram [DEPTH];
  logic [AW-1:0] idx;
  logic          io_sel, rd_fire, ram_we;
  logic [31:0]   io_rdata, rdata_d, rdata_q;
  logic          rd_valid_d, rd_valid_q;
  logic          unused_bits;

  assign idx         = addr[2 +: AW];
  assign io_sel      = addr[15];
  // A simultaneous write wins; the read is dropped entirely.
  assign rd_fire     = ren & ~wen;
  assign ram_we      = wen & ~io_sel;
  assign unused_bits = ^addr;

  always_ff @(posedge clk) begin
    if (ram_we) ram[idx] <= lane_merge(ram[idx], wdata, wmask);
  end

`ifdef MEM_BUS_UART_EN
  logic tx_push, tx_busy, tx_full, tx_ovf, tx_ovf_clr;

  assign tx_push    = wen & io_sel & (addr[3:2] == IO_TXDATA[3:2]) & wmask[3];
  assign tx_ovf_clr = rd_fire & io_sel & (addr[3:2] == IO_STATUS[3:2]);

  mem_bus_uart_tx #(.CLK_DIV(CLK_DIV)) u_uart_tx (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (tx_push),
    .data    (wdata[7:0]),
    .busy    (tx_busy),
    .full    (tx_full),
    .ovf_clr (tx_ovf_clr),
    .ovf     (tx_ovf),
    .tx      (uart_tx)
  );

  always_comb begin
    io_rdata = '0;
    if (addr[3:2] == IO_STATUS[3:2]) begin
      io_rdata[ST_BUSY] = tx_busy;
      io_rdata[ST_FULL] = tx_full;
      io_rdata[ST_OVF]  = tx_ovf;
    end
  end
`else
  localparam int UNUSED_CLK_DIV = CLK_DIV;

  assign io_rdata = '0;
  assign uart_tx  = 1'b1;
`endif

  always_comb begin
    rdata_d    = rdata_q;
    rd_valid_d = rd_fire;
    if (rd_fire) rdata_d = io_sel ? io_rdata : ram[idx];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q    <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rdata_q    <= rdata_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  assign rdata    = rdata_q;
  assign rd_valid = rd_valid_q;

endmodule

// File: tb/tb_mem_bus.sv
// Self-checking bench for mem_bus: time-based behavioural model compared every cycle, plus literal checks.
module tb_mem_bus;

  localparam int DEPTH   = 1024;
  localparam int CLK_DIV = 4;
`ifdef MEM_BUS_UART_EN
  localparam bit UART = 1'b1;
`else
  localparam bit UART = 1'b0;
`endif

  logic        clk = 1'b0, rst_n = 1'b0, ren = 1'b0, wen = 1'b0;
  logic [15:0] addr = '0;
  logic [31:0] wdata = '0;
  logic [3:0]  wmask = '0;
  logic [31:0] rdata;
  logic        rd_valid, uart_tx;

  int n_tests = 0, n_fail = 0;
  bit chk_on = 1'b0;
  bit fall_en = 1'b0;
  int falls = 0;

  mem_bus #(.DEPTH(DEPTH), .INIT_FILE(""), .CLK_DIV(CLK_DIV)) dut (
    .clk(clk), .rst_n(rst_n), .ren(ren), .addr(addr), .rdata(rdata), .rd_valid(rd_valid),
    .wen(wen), .wdata(wdata), .wmask(wmask), .uart_tx(uart_tx)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h, expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit [31:0]  mem_m [int];
  bit [7:0]   q_m [$];
  bit         act_m = 1'b0, ovf_m = 1'b0;
  int         start_m = 0, n_m = 0;
  bit [9:0]   frame_m = '1;
  logic [31:0] rdata_m = '0;
  logic        rdv_m = 1'b0, tx_m = 1'b1;
  int          m_w;
  bit          m_io, m_pop, m_ends;
  bit [1:0]    m_rs;
  bit [31:0]   m_stat, m_word;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_m.delete();
      act_m = 1'b0; ovf_m = 1'b0;
      rdata_m = '0; rdv_m = 1'b0; tx_m = 1'b1;
    end else begin
      n_m++;
      m_w    = int'(addr[14:2]) % DEPTH;
      m_io   = addr[15];
      m_rs   = addr[3:2];
      m_ends = act_m && (n_m - start_m == 10 * CLK_DIV);
      m_pop  = (q_m.size() != 0) && (!act_m || m_ends);
      m_stat = {29'b0, ovf_m, q_m.size() == 4, (q_m.size() != 0) || act_m};
      rdv_m  = ren && !wen;
      if (rdv_m) begin
        if (!m_io) rdata_m = mem_m.exists(m_w) ? mem_m[m_w] : 32'h0;
        else if (UART && m_rs == 2'd1) begin rdata_m = m_stat; ovf_m = 1'b0; end
        else rdata_m = 32'h0;
      end
      if (wen && !m_io) begin
        m_word = mem_m.exists(m_w) ? mem_m[m_w] : 32'h0;
        for (int i = 0; i < 4; i++) if (wmask[3-i]) m_word[8*i +: 8] = wdata[8*i +: 8];
        mem_m[m_w] = m_word;
      end
      if (UART && wen && m_io && m_rs == 2'd0 && wmask[3]) begin
        if (q_m.size() == 4) ovf_m = 1'b1;
        else q_m.push_back(wdata[7:0]);
      end
      if (m_pop) begin
        frame_m = {1'b1, q_m.pop_front(), 1'b0};
        act_m = 1'b1; start_m = n_m;
      end else if (m_ends) act_m = 1'b0;
      tx_m = act_m ? frame_m[(n_m - start_m) / CLK_DIV] : 1'b1;
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      check("cyc_rdata", rdata, rdata_m);
      check("cyc_rd_valid", 32'(rd_valid), 32'(rdv_m));
      check("cyc_uart_tx", 32'(uart_tx), 32'(tx_m));
    end
  end

  always @(negedge uart_tx) if (fall_en) falls++;

  // ---------------- stimulus ----------------
  task automatic drive(input logic r, input logic w, input logic [15:0] a,
                       input logic [31:0] d, input logic [3:0] m);
    @(negedge clk);
    ren = r; wen = w; addr = a; wdata = d; wmask = m;
    @(posedge clk);
    #1;
    ren = 1'b0; wen = 1'b0;
  endtask

  function automatic logic [15:0] pool_addr(input int p);
    logic [9:0] wi;
    wi = 10'(p * 61 + 3);
    return {1'b0, 3'($urandom_range(0, 7)), wi, 2'($urandom_range(0, 3))};
  endfunction

  initial begin
    #1_000_000;
    n_fail++;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    logic [9:0] pat;
    int r;
    pat = 10'b1101001010;

    repeat (3) @(posedge clk);
    #1;
    check("reset_rdata", rdata, 32'h0);
    check("reset_rd_valid", 32'(rd_valid), 32'h0);
    check("reset_uart_tx", 32'(uart_tx), 32'h1);
    @(negedge clk);
    rst_n = 1'b1;
    chk_on = 1'b1;

    // basic word write/read, one-cycle pulse, index aliasing modulo DEPTH
    drive(0, 1, 16'h0100, 32'h11223344, 4'hF);
    drive(1, 0, 16'h0100, 32'h0, 4'h0);
    check("rd_word", rdata, 32'h11223344);
    check("rd_valid_pulse", 32'(rd_valid), 32'h1);
    drive(0, 0, 16'h0, 32'h0, 4'h0);
    check("rd_valid_drop", 32'(rd_valid), 32'h0);
    check("rdata_hold", rdata, 32'h11223344);
    drive(1, 0, 16'h1100, 32'h0, 4'h0);
    check("rd_alias", rdata, 32'h11223344);

    // byte lanes
    drive(0, 1, 16'h0104, 32'hAABBCCDD, 4'hF);
    drive(0, 1, 16'h0104, 32'h00000055, 4'b1000);
    drive(1, 0, 16'h0104, 32'h0, 4'h0);
    check("lane0", rdata, 32'hAABBCC55);
    drive(0, 1, 16'h0104, 32'h66000000, 4'b0001);
    drive(1, 0, 16'h0104, 32'h0, 4'h0);
    check("lane3", rdata, 32'h66BBCC55);

    // collision: write wins, read dropped, next read sees new data
    drive(1, 1, 16'h0200, 32'hDEADBEEF, 4'hF);
    check("coll_rd_valid", 32'(rd_valid), 32'h0);
    check("coll_rdata_hold", rdata, 32'h66BBCC55);
    drive(1, 0, 16'h0200, 32'h0, 4'h0);
    check("coll_raw", rdata, 32'hDEADBEEF);

    // single UART frame of 0xA5
    drive(0, 1, 16'h8000, 32'h000000A5, 4'b1000);
    check("tx_before_start", 32'(uart_tx), 32'h1);
    for (int b = 0; b < 10; b++) begin
      for (int c = 0; c < CLK_DIV; c++) begin
        if (b == 5 && c == 0) begin
          drive(1, 0, 16'h8004, 32'h0, 4'h0);
          check("status_busy", rdata, UART ? 32'h1 : 32'h0);
        end else begin
          drive(0, 0, 16'h0, 32'h0, 4'h0);
        end
        check("tx_bit", 32'(uart_tx), UART ? 32'(pat[b]) : 32'h1);
      end
    end
    drive(0, 0, 16'h0, 32'h0, 4'h0);
    drive(1, 0, 16'h8004, 32'h0, 4'h0);
    check("status_idle", rdata, 32'h0);
    check("status_rd_valid", 32'(rd_valid), 32'h1);

    // six pushes: one pops, four fill, one overflows
    falls = 0;
    fall_en = 1'b1;
    for (int i = 0; i < 6; i++) drive(0, 1, 16'h8000, 32'h000000FF, 4'b1000);
    drive(1, 0, 16'h8004, 32'h0, 4'h0);
    check("status_full_ovf", rdata, UART ? 32'h7 : 32'h0);
    drive(1, 0, 16'h8004, 32'h0, 4'h0);
    check("status_ovf_cleared", rdata, UART ? 32'h3 : 32'h0);
    repeat (280) drive(0, 0, 16'h0, 32'h0, 4'h0);
    fall_en = 1'b0;
    check("frame_count", 32'(falls), UART ? 32'd5 : 32'd0);
    drive(1, 0, 16'h8004, 32'h0, 4'h0);
    check("status_drained", rdata, 32'h0);

    // reset in the middle of a data bit
    drive(0, 1, 16'h0300, 32'hCAFEF00D, 4'hF);
    drive(0, 1, 16'h8000, 32'h00000000, 4'b1000);
    repeat (9) drive(0, 0, 16'h0, 32'h0, 4'h0);
    drive(1, 0, 16'h0100, 32'h0, 4'h0);
    check("pre_rst_rd_valid", 32'(rd_valid), 32'h1);
    check("pre_rst_tx", 32'(uart_tx), UART ? 32'h0 : 32'h1);
    rst_n = 1'b0;
    #2;
    check("rst_async_tx", 32'(uart_tx), 32'h1);
    check("rst_async_rd_valid", 32'(rd_valid), 32'h0);
    check("rst_async_rdata", rdata, 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    drive(1, 0, 16'h8004, 32'h0, 4'h0);
    check("post_rst_status", rdata, 32'h0);
    drive(1, 0, 16'h0300, 32'h0, 4'h0);
    check("post_rst_ram", rdata, 32'hCAFEF00D);

    // randomized traffic against the model
    for (int p = 0; p < 16; p++) drive(0, 1, pool_addr(p), $urandom, 4'hF);
    for (int k = 0; k < 2500; k++) begin
      r = $urandom_range(0, 99);
      if (r < 35)      drive(0, 0, 16'h0, 32'h0, 4'h0);
      else if (r < 60) drive(1, 0, pool_addr($urandom_range(0, 15)), 32'h0, 4'h0);
      else if (r < 80) drive(0, 1, pool_addr($urandom_range(0, 15)), $urandom, 4'($urandom));
      else if (r < 86) drive(0, 1, {14'h2000, 2'($urandom)}, $urandom, 4'($urandom));
      else if (r < 92) drive(1, 0, {14'h2001, 2'($urandom)}, 32'h0, 4'h0);
      else if (r < 95) drive(1, 1, pool_addr($urandom_range(0, 15)), $urandom, 4'($urandom));
      else if (r < 98) drive(1'($urandom), 1'($urandom), {12'h800, 2'($urandom), 2'($urandom)},
                             $urandom, 4'($urandom));
      else             drive(1, 1, {12'h800, 2'($urandom_range(0, 1)), 2'b00}, $urandom, 4'hF);
    end
    repeat (300) drive(0, 0, 16'h0, 32'h0, 4'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
